multicycle_sequencer: RTL
=========================

Name: multicycle_sequencer

Overview:
- Multicycle control FSM for the 32-bit processor. It steps each instruction through FETCH, DECODE, EXEC, MEM, WB and MDWAIT.
- It drives PC/IR/regfile/memory strobes and datapath mux selects from the 5-bit opcode, using the same opcode encoding as the single-cycle control decoder.
- It owns the start/ready handshake to the mult/div unit and bounds that wait with a timeout counter.

Parameters:
- MD_TIMEOUT, 63: max MDWAIT cycles before abort (range 1..63).
- CNT_W, 6: width of the MDWAIT cycle counter.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- opcode  in  5  IR[31:27]; stable from DECODE until next FETCH
- alu_op  in  5  IR[6:2]; 00110=mul, 00111=div (valid only when opcode=00000)
- branch_taken  in  1  ALU compare result (ne for bne, lt for blt), valid in EXEC
- bex_cond  in  1  rstatus != 0, valid in DECODE
- md_ready  in  1  mult/div result valid, 1-cycle pulse
- ir_write  out  1  load IR from imem
- pc_write  out  1  load PC
- pc_src  out  2  0=PC+1, 1=PC+N (PC already incremented), 2=target T, 3=$rd
- reg_write  out  1  regfile write enable
- rd_sel  out  2  0=rd field, 1=r31, 2=r30
- wb_sel  out  3  0=ALU, 1=MEM, 2=PC, 3=T, 4=MD
- alu_b_imm  out  1  ALU B operand: 1=sign-extended immediate, 0=$rt
- mem_write  out  1  dmem write enable
- md_start  out  1  1-cycle start pulse to mult/div
- instr_done  out  1  pulse on the last cycle of each instruction
- md_timeout  out  1  sticky error flag
- state  out  3  0 FETCH, 1 DECODE, 2 EXEC, 3 MEM, 4 WB, 5 MDWAIT

Behaviour:
- Reset (async, any cycle, including mid-MDWAIT): state=FETCH, counter=0, md_timeout=0. While reset is high, all strobes are forced 0 (ir_write, pc_write, reg_write, mem_write, md_start, instr_done) and all selects are 0.
- Outputs are decoded combinationally from state, opcode, alu_op, branch_taken and bex_cond. Only state, counter and md_timeout are registered.
- FETCH: ir_write=1, pc_write=1, pc_src=0. Next state DECODE.
- DECODE, by opcode:
  - j 00001: pc_write, pc_src=2. Done, next FETCH.
  - jal 00011: pc_write, pc_src=2, reg_write, rd_sel=1, wb_sel=2. Done.
  - jr 00100: pc_write, pc_src=3. Done.
  - bex 10110: pc_write=bex_cond, pc_src=2. Done.
  - setx 10101: reg_write, rd_sel=2, wb_sel=3. Done.
  - Rtype 00000 with alu_op mul/div: md_start=1, next MDWAIT.
  - Rtype other, addi 00101, bne 00010, blt 00110, sw 00111, lw 01000: next EXEC.
  - Any other opcode: NOP. instr_done=1, next FETCH.
- EXEC:
  - alu_b_imm=1 for addi, sw, lw.
  - bne/blt: pc_write=branch_taken, pc_src=1, done.
  - sw/lw: next MEM.
  - Rtype/addi: next WB.
- MEM: alu_b_imm=1. sw: mem_write=1, done. lw: next WB.
- WB: reg_write=1, rd_sel=0. wb_sel=1 for lw, 4 for mul/div, 0 otherwise. Done.
- MDWAIT:
  - Counter increments each cycle; it is cleared on entry.
  - md_ready=1: next WB, counter cleared.
  - Counter reaches MD_TIMEOUT-1 with md_ready=0: set md_timeout, no register write, instr_done=1, next FETCH.
  - md_ready and timeout in the same cycle: md_ready wins.
  - md_ready outside MDWAIT is ignored.
  - md_start is never asserted in MDWAIT.
- "Done" means instr_done=1 and next state FETCH.
- Cycle counts: j/jal/jr/bex/setx/NOP 2; bne/blt 3; Rtype/addi/sw 4; lw 5; mul/div 3 + wait cycles.
- No two of reg_write, mem_write, ir_write are ever high together.

Test Plan:
- Reset high, then release; opcode=00101 (addi) -> FETCH(0), DECODE(1), EXEC(2) with alu_b_imm=1, WB(4) with reg_write=1, wb_sel=0; instr_done only in cycle 4.
- lw 01000 then sw 00111 -> lw takes 5 cycles, with wb_sel=1 in WB. sw takes 4 cycles, with mem_write=1 only in MEM and reg_write never asserted.
- bne with branch_taken=1, then with branch_taken=0 -> EXEC pc_write=1 pc_src=1 in the first case, pc_write=0 in the second; 3 cycles each.
- jal -> DECODE pc_write=1, pc_src=2, reg_write=1, rd_sel=1, wb_sel=2. bex with bex_cond=0 -> pc_write=0, instr_done=1.
- mul (opcode 0, alu_op 00110), md_ready after 5 MDWAIT cycles -> md_start one pulse in DECODE, WB wb_sel=4. Then div with md_ready never asserted -> md_timeout=1 after 63 MDWAIT cycles, next FETCH, no reg_write.
- Reset asserted in the 3rd MDWAIT cycle -> state=0 immediately (async), all strobes 0, md_timeout=0. After release, the FETCH sequence resumes normally.

Source files
------------

// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: multicycle control FSM with a bounded mult/div handshake
module multicycle_sequencer #(
    parameter int MD_TIMEOUT = 63,
    parameter int CNT_W      = 6
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [4:0] opcode,
    input  logic [4:0] alu_op,
    input  logic       branch_taken,
    input  logic       bex_cond,
    input  logic       md_ready,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       reg_write,
    output logic [1:0] rd_sel,
    output logic [2:0] wb_sel,
    output logic       alu_b_imm,
    output logic       mem_write,
    output logic       md_start,
    output logic       instr_done,
    output logic       md_timeout,
    output logic [2:0] state
);
    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        MDWAIT = 3'd5
    } state_t;

    state_t           cur, nxt;
    logic [CNT_W-1:0] cnt;
    logic             to_set;
    logic             is_r, is_md, is_j, is_jal, is_jr, is_bex, is_setx;
    logic             is_addi, is_bne, is_blt, is_sw, is_lw;

    assign is_r    = opcode == 5'b00000;
    assign is_md   = is_r && (alu_op == 5'b00110 || alu_op == 5'b00111);
    assign is_j    = opcode == 5'b00001;
    assign is_bne  = opcode == 5'b00010;
    assign is_jal  = opcode == 5'b00011;
    assign is_jr   = opcode == 5'b00100;
    assign is_addi = opcode == 5'b00101;
    assign is_blt  = opcode == 5'b00110;
    assign is_sw   = opcode == 5'b00111;
    assign is_lw   = opcode == 5'b01000;
    assign is_setx = opcode == 5'b10101;
    assign is_bex  = opcode == 5'b10110;
    assign state   = cur;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cur        <= FETCH;
            cnt        <= '0;
            md_timeout <= 1'b0;
        end else begin
            cur        <= nxt;
            cnt        <= (cur == MDWAIT && nxt == MDWAIT) ? cnt + 1'b1 : '0;
            md_timeout <= md_timeout | to_set;
        end
    end

    always_comb begin
        nxt        = cur;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 2'd0;
        reg_write  = 1'b0;
        rd_sel     = 2'd0;
        wb_sel     = 3'd0;
        alu_b_imm  = 1'b0;
        mem_write  = 1'b0;
        md_start   = 1'b0;
        instr_done = 1'b0;
        to_set     = 1'b0;
        case (cur)
            FETCH: begin
                ir_write = 1'b1;
                pc_write = 1'b1;
                nxt      = DECODE;
            end
            DECODE: begin
                if (is_j || is_jal || is_jr || is_bex) begin
                    pc_write = is_bex ? bex_cond : 1'b1;
                    pc_src   = is_jr ? 2'd3 : 2'd2;
                end
                if (is_jal || is_setx) begin
                    reg_write = 1'b1;
                    rd_sel    = is_jal ? 2'd1 : 2'd2;
                    wb_sel    = is_jal ? 3'd2 : 3'd3;
                end
                if (is_md) begin
                    md_start = 1'b1;
                    nxt      = MDWAIT;
                end else if (is_r || is_addi || is_bne || is_blt || is_sw || is_lw) begin
                    nxt = EXEC;
                end else begin
                    instr_done = 1'b1;
                    nxt        = FETCH;
                end
            end
            EXEC: begin
                alu_b_imm = is_addi || is_sw || is_lw;
                if (is_bne || is_blt) begin
                    pc_write   = branch_taken;
                    pc_src     = 2'd1;
                    instr_done = 1'b1;
                    nxt        = FETCH;
                end else begin
                    nxt = (is_sw || is_lw) ? MEM : WB;
                end
            end
            MEM: begin
                alu_b_imm  = 1'b1;
                mem_write  = is_sw;
                instr_done = is_sw;
                nxt        = is_sw ? FETCH : WB;
            end
            WB: begin
                reg_write  = 1'b1;
                wb_sel     = is_lw ? 3'd1 : is_md ? 3'd4 : 3'd0;
                instr_done = 1'b1;
                nxt        = FETCH;
            end
            MDWAIT: begin
                // a result arriving on the last allowed cycle still beats the abort
                if (md_ready) begin
                    nxt = WB;
                end else if (cnt == CNT_W'(MD_TIMEOUT - 1)) begin
                    to_set     = 1'b1;
                    instr_done = 1'b1;
                    nxt        = FETCH;
                end
            end
            default: nxt = FETCH;
        endcase
        if (reset) begin
            ir_write   = 1'b0;
            pc_write   = 1'b0;
            pc_src     = 2'd0;
            reg_write  = 1'b0;
            rd_sel     = 2'd0;
            wb_sel     = 3'd0;
            alu_b_imm  = 1'b0;
            mem_write  = 1'b0;
            md_start   = 1'b0;
            instr_done = 1'b0;
            to_set     = 1'b0;
        end
    end
endmodule
